// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, registered datapath selects and a sticky trap.
module multicycle_control #(
  parameter int EN_MUL  = 1,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [1:0] addr_lo,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_we,
  output logic       dmem_req,
  output logic [3:0] dmem_we,
  input  logic       dmem_ack,
  output logic       pc_we,
  output logic       rd_write,
  output logic [3:0] aluSel,
  output logic       aluSrc1Sel,
  output logic [1:0] aluSrc2Sel,
  output logic [1:0] wbSel,
  output logic [2:0] pcSel,
  output logic       trap,
  output logic [1:0] trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {CL_OTHER, CL_BRANCH, CL_LOAD, CL_STORE} class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_MULH  = 4'd11;
  localparam logic [3:0] ALU_MULHU = 4'd12;
  localparam logic [3:0] ALU_NONE  = 4'd13;
  localparam logic [3:0] ALU_PASS2 = 4'd14;

  localparam logic [1:0] SRC2_RS2 = 2'd0;
  localparam logic [1:0] SRC2_S   = 2'd1;
  localparam logic [1:0] SRC2_I   = 2'd2;
  localparam logic [1:0] SRC2_U   = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] PC_SEQ  = 3'd0;
  localparam logic [2:0] PC_REL  = 3'd1;
  localparam logic [2:0] PC_JALR = 3'd2;

  localparam logic [1:0] CAUSE_ILL = 2'd1;
  localparam logic [1:0] CAUSE_WD  = 2'd2;
  localparam logic [1:0] CAUSE_MIS = 2'd3;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t          state_q, state_d;
  class_t          cls_q, dec_cls;
  logic [1:0]      size_q;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [3:0]      alu_q, dec_alu;
  logic            src1_q, dec_src1;
  logic [1:0]      src2_q, dec_src2;
  logic [1:0]      wb_q, dec_wb;
  logic [2:0]      pcs_q, dec_pcs;
  logic [1:0]      cause_q, cause_d;
  logic            dec_legal;
  logic            misaligned;
  logic            wd_expire;
  logic [3:0]      store_mask;

  function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = CL_OTHER;
    dec_alu   = ALU_NONE;
    dec_src1  = 1'b0;
    dec_src2  = SRC2_RS2;
    dec_wb    = WB_ALU;
    dec_pcs   = PC_SEQ;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000)                           dec_alu = alu_base(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)  dec_alu = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)  dec_alu = ALU_SRA;
        else if (EN_MUL != 0 && funct7 == 7'b0000001 && funct3 == 3'b000) dec_alu = ALU_MUL;
        else if (EN_MUL != 0 && funct7 == 7'b0000001 && funct3 == 3'b001) dec_alu = ALU_MULH;
        else if (EN_MUL != 0 && funct7 == 7'b0000001 && funct3 == 3'b011) dec_alu = ALU_MULHU;
        else                                                dec_legal = 1'b0;
      end
      OP_IMM: begin
        dec_src2 = SRC2_I;
        dec_alu  = alu_base(funct3, funct7[5]);
      end
      OP_LUI: begin
        dec_src2 = SRC2_U;
        dec_alu  = ALU_PASS2;
      end
      OP_AUIPC: begin
        dec_src1 = 1'b1;
        dec_src2 = SRC2_U;
        dec_alu  = ALU_ADD;
      end
      OP_LOAD: begin
        dec_legal = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        dec_cls   = CL_LOAD;
        dec_src2  = SRC2_I;
        dec_alu   = ALU_ADD;
        dec_wb    = WB_LOAD;
      end
      OP_STORE: begin
        dec_legal = (funct3 < 3'd3);
        dec_cls   = CL_STORE;
        dec_src2  = SRC2_S;
        dec_alu   = ALU_ADD;
      end
      OP_JAL: begin
        dec_wb  = WB_PC4;
        dec_pcs = PC_REL;
      end
      OP_JALR: begin
        dec_src2 = SRC2_I;
        dec_alu  = ALU_ADD;
        dec_wb   = WB_PC4;
        dec_pcs  = PC_JALR;
      end
      OP_BRANCH: begin
        dec_legal = !(funct3 == 3'd2 || funct3 == 3'd3);
        dec_cls   = CL_BRANCH;
        dec_alu   = ALU_SUB;
        dec_pcs   = PC_REL;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // size_q holds funct3[1:0]: 0 byte, 1 half, 2 word (unsigned loads share the low bits)
  always_comb begin
    misaligned = 1'b0;
    store_mask = 4'b1111;
    case (size_q)
      2'd0: store_mask = 4'b0001 << addr_lo;
      2'd1: begin
        misaligned = addr_lo[0];
        store_mask = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 4'b0000;
    pc_we    = 1'b0;
    rd_write = 1'b0;
    pcSel    = pcs_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wd_expire) begin
          state_d = S_TRAP;
          cause_d = CAUSE_WD;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pcSel   = br_taken ? PC_REL : PC_SEQ;
            state_d = S_FETCH;
          end
          CL_LOAD, CL_STORE: begin
            if (misaligned) begin
              state_d = S_TRAP;
              cause_d = CAUSE_MIS;
            end else begin
              state_d = S_MEM;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (cls_q == CL_STORE) dmem_we = store_mask;
        if (dmem_ack) begin
          if (cls_q == CL_STORE) begin
            pc_we   = 1'b1;
            pcSel   = PC_SEQ;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expire) begin
          state_d = S_TRAP;
          cause_d = CAUSE_WD;
        end
      end
      S_WB: begin
        rd_write = 1'b1;
        pc_we    = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Enables are squashed during reset so an ack arriving then cannot load the IR.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 4'b0000;
      pc_we    = 1'b0;
      rd_write = 1'b0;
    end
  end

  // Watchdog restarts whenever FETCH or MEM is entered and counts while waiting there.
  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) && (state_q == S_FETCH || state_q == S_MEM)) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
      cause_q <= 2'd0;
      cls_q   <= CL_OTHER;
      size_q  <= 2'd0;
      alu_q   <= 4'd0;
      src1_q  <= 1'b0;
      src2_q  <= 2'd0;
      wb_q    <= 2'd0;
      pcs_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE) begin
        cls_q  <= dec_cls;
        size_q <= funct3[1:0];
        alu_q  <= dec_alu;
        src1_q <= dec_src1;
        src2_q <= dec_src2;
        wb_q   <= dec_wb;
        pcs_q  <= dec_pcs;
      end
    end
  end

  assign aluSel     = alu_q;
  assign aluSrc1Sel = src1_q;
  assign aluSrc2Sel = src2_q;
  assign wbSel      = wb_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams against
// a phase-level model, plus watchdog, EN_MUL=0 and reset scenarios.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int K_OTH = 0;
  localparam int K_BR  = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [1:0] addr_lo;
  logic       br_taken, imem_ack, dmem_ack;

  logic       imem_req_a, ir_we_a, dmem_req_a, pc_we_a, rd_write_a, aluSrc1Sel_a, trap_a;
  logic [3:0] dmem_we_a, aluSel_a;
  logic [1:0] aluSrc2Sel_a, wbSel_a, trap_cause_a;
  logic [2:0] pcSel_a;
  logic       imem_req_b, ir_we_b, dmem_req_b, pc_we_b, rd_write_b, aluSrc1Sel_b, trap_b;
  logic [3:0] dmem_we_b, aluSel_b;
  logic [1:0] aluSrc2Sel_b, wbSel_b, trap_cause_b;
  logic [2:0] pcSel_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.EN_MUL(1), .TIMEOUT(64), .TO_W(7)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .addr_lo(addr_lo), .br_taken(br_taken), .imem_req(imem_req_a), .imem_ack(imem_ack),
    .ir_we(ir_we_a), .dmem_req(dmem_req_a), .dmem_we(dmem_we_a), .dmem_ack(dmem_ack),
    .pc_we(pc_we_a), .rd_write(rd_write_a), .aluSel(aluSel_a), .aluSrc1Sel(aluSrc1Sel_a),
    .aluSrc2Sel(aluSrc2Sel_a), .wbSel(wbSel_a), .pcSel(pcSel_a), .trap(trap_a),
    .trap_cause(trap_cause_a));

  multicycle_control #(.EN_MUL(0), .TIMEOUT(4), .TO_W(3)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .addr_lo(addr_lo), .br_taken(br_taken), .imem_req(imem_req_b), .imem_ack(imem_ack),
    .ir_we(ir_we_b), .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_ack(dmem_ack),
    .pc_we(pc_we_b), .rd_write(rd_write_b), .aluSel(aluSel_b), .aluSrc1Sel(aluSrc1Sel_b),
    .aluSrc2Sel(aluSrc2Sel_b), .wbSel(wbSel_b), .pcSel(pcSel_b), .trap(trap_b),
    .trap_cause(trap_cause_b));

  wire [9:0]  en_a  = {imem_req_a, ir_we_a, dmem_req_a, dmem_we_a, pc_we_a, rd_write_a, trap_a};
  wire [9:0]  en_b  = {imem_req_b, ir_we_b, dmem_req_b, dmem_we_b, pc_we_b, rd_write_b, trap_b};
  wire [11:0] dec_a = {aluSel_a, aluSrc1Sel_a, aluSrc2Sel_a, wbSel_a, pcSel_a};
  wire [11:0] dec_b = {aluSel_b, aluSrc1Sel_b, aluSrc2Sel_b, wbSel_b, pcSel_b};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] ad;
    logic       br;
    int         idly;
    int         ddly;
  } instr_t;

  function automatic logic [9:0] mk_en(input logic ireq, input logic irw, input logic dreq,
                                       input logic [3:0] dwe, input logic pcw, input logic rdw,
                                       input logic trp);
    return {ireq, irw, dreq, dwe, pcw, rdw, trp};
  endfunction

  // Decode table from the instruction set rules; dec = {alu, src1, src2, wb, pc}
  function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input bit mul_en,
                                     output bit legal, output int cls,
                                     output logic [11:0] dec, output logic [11:0] mask);
    logic [3:0] base [8];
    logic [3:0] alu;
    logic s1;
    logic [1:0] s2, wb;
    logic [2:0] pc;
    base = '{4'd2, 4'd6, 4'd4, 4'd7, 4'd5, 4'd8, 4'd1, 4'd0};
    legal = 1; cls = K_OTH; mask = 12'hFFF;
    alu = 4'd0; s1 = 0; s2 = 0; wb = 0; pc = 0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'h00) alu = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 4'd3;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 4'd9;
        else if (f7 == 7'h01 && mul_en && f3 == 3'd0) alu = 4'd10;
        else if (f7 == 7'h01 && mul_en && f3 == 3'd1) alu = 4'd11;
        else if (f7 == 7'h01 && mul_en && f3 == 3'd3) alu = 4'd12;
        else legal = 0;
      end
      7'b0010011: begin s2 = 2; alu = (f3 == 3'd5 && f7[5]) ? 4'd9 : base[f3]; end
      7'b0110111: begin s2 = 3; alu = 4'd14; mask[7] = 1'b0; end
      7'b0010111: begin s1 = 1; s2 = 3; alu = 4'd2; end
      7'b0000011: begin
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        cls = K_LD; s2 = 2; alu = 4'd2; wb = 1;
      end
      7'b0100011: begin
        legal = (f3 < 3'd3); cls = K_ST; s2 = 1; alu = 4'd2; mask[4:3] = 2'b00;
      end
      7'b1101111: begin wb = 2; pc = 1; mask = 12'h01F; end
      7'b1100111: begin s2 = 2; alu = 4'd2; wb = 2; pc = 2; end
      7'b1100011: begin
        legal = !(f3 == 3'd2 || f3 == 3'd3); cls = K_BR; alu = 4'd3; mask[4:3] = 2'b00;
      end
      default: legal = 0;
    endcase
    dec = {alu, s1, s2, wb, pc};
  endfunction

  task automatic apply_reset();
    rst = 1; imem_ack = 0; dmem_ack = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; imem_ack = 1; dmem_ack = 1;
    @(posedge clk); #1;
    #3;
    total++;
    if ({imem_req_a, ir_we_a, imem_req_b, ir_we_b} !== 4'b0000) begin
      bad++; $display("FAIL reset_req got=%b want=0000", {imem_req_a, ir_we_a, imem_req_b, ir_we_b});
    end
    @(posedge clk); #1;
    rst = 0; imem_ack = 0; dmem_ack = 0;
    #3;
    total++;
    if (en_a !== mk_en(1, 0, 0, 4'h0, 0, 0, 0) || en_b !== mk_en(1, 0, 0, 4'h0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_en got=%h/%h want=%h", en_a, en_b, mk_en(1, 0, 0, 4'h0, 0, 0, 0));
    end
    total++;
    if ({dec_a, trap_cause_a} !== 14'h0) begin
      bad++; $display("FAIL reset_regs got=%h want=0", {dec_a, trap_cause_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_program();
    instr_t dir [9];
    instr_t t;
    bit legal, mis;
    int cls, k, we_i;
    logic [11:0] edec, emask;
    logic [3:0] ewe;
    dir[0] = '{7'b0010011, 3'd0, 7'h00, 2'd0, 1'b0, 0, 0};  // ADDI
    dir[1] = '{7'b0100011, 3'd0, 7'h00, 2'd2, 1'b0, 0, 3};  // SB
    dir[2] = '{7'b0100011, 3'd2, 7'h00, 2'd1, 1'b0, 1, 0};  // SW misaligned
    dir[3] = '{7'b0000011, 3'd1, 7'h00, 2'd2, 1'b0, 0, 1};  // LH
    dir[4] = '{7'b1100011, 3'd0, 7'h00, 2'd0, 1'b1, 2, 0};  // BEQ taken
    dir[5] = '{7'b1100011, 3'd0, 7'h00, 2'd0, 1'b0, 0, 0};  // BEQ not taken
    dir[6] = '{7'b0110011, 3'd0, 7'h01, 2'd0, 1'b0, 0, 0};  // MUL
    dir[7] = '{7'b1101111, 3'd5, 7'h3A, 2'd3, 1'b0, 1, 0};  // JAL
    dir[8] = '{7'b1110011, 3'd0, 7'h00, 2'd0, 1'b0, 0, 0};  // SYSTEM: illegal
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      if (n < 9) begin
        t = dir[n];
      end else begin
        k = $urandom_range(0, 10);
        t.f3 = 3'($urandom_range(0, 7));
        t.f7 = 7'($urandom_range(0, 127));
        case (k)
          0: begin
            t.op = 7'b0110011;
            case ($urandom_range(0, 3))
              0: t.f7 = 7'h00;
              1: t.f7 = 7'h20;
              2: t.f7 = 7'h01;
              default: ;
            endcase
          end
          1: begin
            t.op = 7'b0010011;
            if (t.f3 == 3'd1) t.f7 = 7'h00;
            if (t.f3 == 3'd5) t.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          end
          2: t.op = 7'b0110111;
          3: t.op = 7'b0010111;
          4, 5: t.op = 7'b0000011;
          6, 7: t.op = 7'b0100011;
          8: t.op = 7'b1101111;
          9: t.op = 7'b1100111;
          default: t.op = 7'b1100011;
        endcase
        if ($urandom_range(0, 15) == 0) t.op = 7'b0001111;
        t.ad   = 2'($urandom_range(0, 3));
        t.br   = 1'($urandom_range(0, 1));
        t.idly = $urandom_range(0, 3);
        t.ddly = $urandom_range(0, 3);
      end
      ref_decode(t.op, t.f3, t.f7, 1'b1, legal, cls, edec, emask);
      opcode = t.op; funct3 = t.f3; funct7 = t.f7; addr_lo = t.ad; br_taken = t.br;
      for (int c = 0; c <= t.idly; c++) begin
        imem_ack = (c == t.idly);
        #3;
        total++;
        if (en_a !== mk_en(1, c == t.idly, 0, 4'h0, 0, 0, 0)) begin
          bad++; $display("FAIL fetch n=%0d c=%0d got=%h want=%h", n, c, en_a,
                          mk_en(1, c == t.idly, 0, 4'h0, 0, 0, 0));
        end
        @(posedge clk); #1;
      end
      imem_ack = 0;
      #3;
      total++;
      if (en_a !== 10'h0) begin bad++; $display("FAIL decode_en n=%0d got=%h want=0", n, en_a); end
      @(posedge clk); #1;
      if (!legal) begin
        #3;
        total++;
        if ({en_a, trap_cause_a} !== {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd1}) begin
          bad++; $display("FAIL illegal n=%0d got=%h want=%h", n, {en_a, trap_cause_a},
                          {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd1});
        end
        @(posedge clk); #1;
        imem_ack = 1;
        #3;
        total++;
        if ({en_a, trap_cause_a} !== {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd1}) begin
          bad++; $display("FAIL trap_sticky n=%0d got=%h", n, {en_a, trap_cause_a});
        end
        apply_reset();
        continue;
      end
      #3;
      if (cls == K_BR) edec[2:0] = t.br ? 3'd1 : 3'd0;
      total++;
      if ((dec_a & emask) !== (edec & emask)) begin
        bad++; $display("FAIL exec_dec n=%0d op=%b got=%h want=%h", n, t.op, dec_a & emask, edec & emask);
      end
      total++;
      if (en_a !== mk_en(0, 0, 0, 4'h0, cls == K_BR, 0, 0)) begin
        bad++; $display("FAIL exec_en n=%0d got=%h want=%h", n, en_a, mk_en(0, 0, 0, 4'h0, cls == K_BR, 0, 0));
      end
      @(posedge clk); #1;
      if (cls == K_BR) continue;
      mis = (cls == K_LD || cls == K_ST) &&
            ((t.f3[1:0] == 2'd1 && t.ad[0]) || (t.f3[1:0] == 2'd2 && t.ad != 2'd0));
      if (mis) begin
        #3;
        total++;
        if ({en_a, trap_cause_a} !== {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd3}) begin
          bad++; $display("FAIL misaligned n=%0d got=%h want=%h", n, {en_a, trap_cause_a},
                          {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd3});
        end
        apply_reset();
        continue;
      end
      if (cls == K_LD || cls == K_ST) begin
        we_i = (t.f3[1:0] == 2'd0) ? (1 << t.ad) : (t.f3[1:0] == 2'd1) ? (3 << (t.ad & 2'd2)) : 15;
        ewe  = (cls == K_ST) ? we_i[3:0] : 4'h0;
        for (int c = 0; c <= t.ddly; c++) begin
          dmem_ack = (c == t.ddly);
          #3;
          total++;
          if (en_a !== mk_en(0, 0, 1, ewe, cls == K_ST && c == t.ddly, 0, 0) ||
              (cls == K_ST && c == t.ddly && pcSel_a !== 3'd0)) begin
            bad++; $display("FAIL mem n=%0d c=%0d got=%h/%0d want=%h", n, c, en_a, pcSel_a,
                            mk_en(0, 0, 1, ewe, cls == K_ST && c == t.ddly, 0, 0));
          end
          @(posedge clk); #1;
        end
        dmem_ack = 0;
        if (cls == K_ST) continue;
      end
      #3;
      total++;
      if (en_a !== mk_en(0, 0, 0, 4'h0, 1, 1, 0) || (dec_a & emask) !== (edec & emask)) begin
        bad++; $display("FAIL wb n=%0d got=%h/%h want=%h/%h", n, en_a, dec_a & emask,
                        mk_en(0, 0, 0, 4'h0, 1, 1, 0), edec & emask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    apply_reset();
    opcode = 7'b0110011; funct3 = 3'd3; funct7 = 7'h01; imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0;
    @(posedge clk); #1;
    #3;
    total++;
    if (aluSel_a !== 4'd12 || trap_a !== 1'b0) begin
      bad++; $display("FAIL mul_en1 got=%0d/%b want=12/0", aluSel_a, trap_a);
    end
    total++;
    if ({trap_b, trap_cause_b} !== 3'b101) begin
      bad++; $display("FAIL mul_en0 got=%b want=101", {trap_b, trap_cause_b});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog_b();
    apply_reset();
    opcode = 7'b0010011; funct3 = 3'd0; funct7 = 7'h00; addr_lo = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      total++;
      if (en_b !== mk_en(1, 0, 0, 4'h0, 0, 0, 0)) begin
        bad++; $display("FAIL wd_wait c=%0d got=%h", c, en_b);
      end
      @(posedge clk); #1;
    end
    #3;
    total++;
    if ({en_b, trap_cause_b} !== {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd2}) begin
      bad++; $display("FAIL wd_trap got=%h want=%h", {en_b, trap_cause_b}, {mk_en(0, 0, 0, 4'h0, 0, 0, 1), 2'd2});
    end
    apply_reset();
    #3;
    total++;
    if ({trap_b, trap_cause_b} !== 3'b000) begin
      bad++; $display("FAIL wd_rst_clear got=%b want=000", {trap_b, trap_cause_b});
    end
    @(posedge clk); #1;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      imem_ack = (c == 3);
      @(posedge clk); #1;
    end
    imem_ack = 0;
    #3;
    total++;
    if (en_b !== 10'h0) begin bad++; $display("FAIL wd_late_ack got=%h want=0", en_b); end
    @(posedge clk); #1;
    #3;
    total++;
    if (trap_b !== 1'b0 || dec_b[11:8] !== 4'd2 || dec_b[6:5] !== 2'd2) begin
      bad++; $display("FAIL wd_late_exec got=%b/%h", trap_b, dec_b);
    end
    apply_reset();
    opcode = 7'b0000011; funct3 = 3'd2; imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0;
    repeat (2) begin @(posedge clk); #1; end
    for (int c = 0; c < 4; c++) begin
      #3;
      total++;
      if (dmem_req_b !== 1'b1 || trap_b !== 1'b0) begin
        bad++; $display("FAIL wd_mem_wait c=%0d got=%b%b want=10", c, dmem_req_b, trap_b);
      end
      @(posedge clk); #1;
    end
    #3;
    total++;
    if ({dmem_req_b, trap_b, trap_cause_b} !== 4'b0110) begin
      bad++; $display("FAIL wd_mem_trap got=%b want=0110", {dmem_req_b, trap_b, trap_cause_b});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog_a();
    int cyc;
    apply_reset();
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (trap_a) break;
      cyc++;
      @(posedge clk); #1;
    end
    total++;
    if (cyc !== 64 || trap_cause_a !== 2'd2) begin
      bad++; $display("FAIL wd64 got=%0d/%0d want=64/2", cyc, trap_cause_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    opcode = 7'b0000011; funct3 = 3'd2; funct7 = 7'h00; addr_lo = 0; imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0;
    repeat (2) begin @(posedge clk); #1; end
    #3;
    total++;
    if (dmem_req_a !== 1'b1) begin bad++; $display("FAIL midop_pending got=%b want=1", dmem_req_a); end
    rst = 1; dmem_ack = 1; imem_ack = 1;
    @(posedge clk); #1;
    #3;
    total++;
    if ({imem_req_a, ir_we_a} !== 2'b00) begin
      bad++; $display("FAIL midop_rst got=%b want=00", {imem_req_a, ir_we_a});
    end
    @(posedge clk); #1;
    rst = 0; dmem_ack = 0; imem_ack = 0;
    #3;
    total++;
    if (en_a !== mk_en(1, 0, 0, 4'h0, 0, 0, 0) || dec_a !== 12'h0) begin
      bad++; $display("FAIL midop_fetch got=%h/%h", en_a, dec_a);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; opcode = 0; funct3 = 0; funct7 = 0; addr_lo = 0;
    br_taken = 0; imem_ack = 0; dmem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_program();
    test_mul();
    test_watchdog_b();
    test_watchdog_a();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
